path_mem_arbiter: RTL

//  Shares the single-port path memory between three requesters:
//    0 = playback sequencer (read), 1 = route recorder (write), 2 = host dump port (read).
//  A path memory entry is {Direction[2:0], Count[13:0]}.

---
 rtl/path_mem_arbiter_pkg.sv | 23 ++
 rtl/path_mem_arbiter_rr_pick3.sv | 46 ++++
 rtl/path_mem_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/path_mem_arbiter_pkg.sv
// Shared definitions for the path memory arbiter: FSM states, requester indices,
// and a small one-hot helper.
package path_mem_arbiter_pkg;

  localparam int unsigned NumReq = 3;

  localparam logic [1:0] ReqPlay = 2'd0;
  localparam logic [1:0] ReqRec  = 2'd1;
  localparam logic [1:0] ReqHost = 2'd2;

  typedef enum logic [1:0] {
    StArb  = 2'd0,
    StMem  = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic [NumReq-1:0] onehot3(input logic [1:0] idx);
    logic [NumReq-1:0] res;
    res = 3'b001 << idx;
    return res;
  endfunction

endpackage

// File: rtl/path_mem_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters; search starts just after
// the last winner and wraps round to it.
module path_mem_arbiter_rr_pick3
  import path_mem_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic [1:0]        last_i,
  output logic [1:0]        win_o,
  output logic              any_o
);

  logic [1:0] first, second, third;

  always_comb begin
    first  = ReqPlay;
    second = ReqRec;
    third  = ReqHost;
    case (last_i)
      ReqPlay: begin
        first  = ReqRec;
        second = ReqHost;
        third  = ReqPlay;
      end
      ReqRec: begin
        first  = ReqHost;
        second = ReqPlay;
        third  = ReqRec;
      end
      default: begin
        first  = ReqPlay;
        second = ReqRec;
        third  = ReqHost;
      end
    endcase

    if (req_i[first]) begin
      win_o = first;
    end else if (req_i[second]) begin
      win_o = second;
    end else begin
      win_o = third;
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/path_mem_arbiter.sv
// Round-robin arbiter giving three requesters serial, one-transaction-at-a-time
// access to the single-port path RAM. Sole driver of the RAM pins.
module path_mem_arbiter
  import path_mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 17
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq-1:0]       req_wr_i,
  input  logic [NumReq*AddrW-1:0] req_addr_i,
  input  logic [NumReq*DataW-1:0] req_wdata_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       rd_valid_o,
  output logic [DataW-1:0]        rd_data_o,
  output logic                    busy_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [AddrW-1:0]        mem_addr_o,
  output logic [DataW-1:0]        mem_wdata_o,
  input  logic [DataW-1:0]        mem_rdata_i
);

  state_e            state_q;
  logic [1:0]        last_q;
  logic [1:0]        win_q;
  logic [NumReq-1:0] gnt_q;
  logic [NumReq-1:0] rd_valid_q;
  logic [DataW-1:0]  rd_data_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [AddrW-1:0]  mem_addr_q;
  logic [DataW-1:0]  mem_wdata_q;

  logic [1:0] win;
  logic       any;

  path_mem_arbiter_rr_pick3 u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any)
  );

  // Strobes default low each cycle so Gnt/RdValid/MemEn are single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StArb;
      last_q      <= ReqHost;
      win_q       <= ReqPlay;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q      <= '0;
      rd_valid_q <= '0;
      mem_en_q   <= 1'b0;
      case (state_q)
        StArb: begin
          if (any) begin
            state_q     <= StMem;
            last_q      <= win;
            win_q       <= win;
            gnt_q       <= onehot3(win);
            mem_en_q    <= 1'b1;
            mem_we_q    <= req_wr_i[win];
            mem_addr_q  <= req_addr_i[win*AddrW +: AddrW];
            mem_wdata_q <= req_wdata_i[win*DataW +: DataW];
          end
        end
        StMem: begin
          mem_we_q <= 1'b0;
          state_q  <= mem_we_q ? StArb : StResp;
        end
        StResp: begin
          rd_data_q  <= mem_rdata_i;
          rd_valid_q <= onehot3(win_q);
          state_q    <= StArb;
        end
        default: begin
          state_q <= StArb;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign busy_o      = (state_q != StArb);
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
